// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : State encodings and default width shared by the sequential
//               multiplier and divider.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int c_default_width = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step: shift, trial
//               subtract, restore and produce the next quotient bit.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] work,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] work_next
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_borrow;

    assign w_shift = {rem, work[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, divisor};
    // rem < divisor always holds, so the top bit of the WIDTH+1 difference is the exact borrow
    assign w_borrow = w_diff[WIDTH];

    assign rem_next  = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign work_next = {work[WIDTH-2:0], ~w_borrow};

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Unsigned restoring divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import muldiv_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder
);

    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_divisor;
    logic             r_busy;
    logic             r_done;
    logic             r_divzero;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_work_next;

    // r_work starts as the dividend and fills with quotient bits from the right
    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem       (r_rem),
        .work      (r_work),
        .divisor   (r_divisor),
        .rem_next  (w_rem_next),
        .work_next (w_work_next)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_work      <= '0;
            r_divisor   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_divzero   <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        if (Divisor == '0) begin
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_divzero   <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= Dividend;
                        end else begin
                            r_state   <= CALC;
                            r_busy    <= 1'b1;
                            r_divzero <= 1'b0;
                            r_rem     <= '0;
                            r_work    <= Dividend;
                            r_divisor <= Divisor;
                            r_cnt     <= '0;
                        end
                    end
                end
                CALC: begin
                    r_rem  <= w_rem_next;
                    r_work <= w_work_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_last_step) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_quotient  <= w_work_next;
                        r_remainder <= w_rem_next;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign DivZero   = r_divzero;
    assign Quotient  = r_quotient;
    assign Remainder = r_remainder;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider with an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int W = 32;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic         Busy;
    logic         Done;
    logic         DivZero;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    seq_divider #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero),
        .Quotient  (Quotient),
        .Remainder (Remainder)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request yields Dividend/Divisor after W busy cycles
    logic         m_busy, m_done, m_dz;
    logic [W-1:0] m_q, m_r, p_q, p_r;
    int           m_left;

    always @(posedge Clk) begin
        if (Reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
            m_q <= '0; m_r <= '0; m_left <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_q <= p_q; m_r <= p_r;
            end
        end else if (Start) begin
            if (Divisor == '0) begin
                m_done <= 1'b1; m_dz <= 1'b1; m_q <= '1; m_r <= Dividend;
            end else begin
                p_q <= Dividend / Divisor;
                p_r <= Dividend % Divisor;
                m_left <= W; m_busy <= 1'b1; m_dz <= 1'b0;
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("busy", {63'd0, Busy}, {63'd0, m_busy});
            check("done", {63'd0, Done}, {63'd0, m_done});
            check("divzero", {63'd0, DivZero}, {63'd0, m_dz});
            check("quotient", {32'd0, Quotient}, {32'd0, m_q});
            check("remainder", {32'd0, Remainder}, {32'd0, m_r});
        end
    end

    // Called at a negedge; returns negedges from the Start edge to Done and busy cycles seen
    task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                          output int lat, output int bcnt);
        Dividend = dd; Divisor = dv; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        lat = 1; bcnt = 0;
        while (!Done && lat < 100) begin
            if (Busy) bcnt++;
            @(negedge Clk);
            lat++;
        end
        if (!Done) check("done_timeout", 64'd0, 64'd1);
    endtask

    int lat, bcnt, ndone;
    logic [W-1:0] tbl_dd [4] = '{32'd1000, 32'd0, 32'd7, 32'hDEADBEEF};
    logic [W-1:0] tbl_dv [4] = '{32'd3, 32'd9, 32'd8, 32'h1234};

    initial begin
        // Reset must win over a simultaneous Start
        Reset = 1'b1; Start = 1'b1; Dividend = 32'd9; Divisor = 32'd3;
        repeat (3) @(negedge Clk);
        Start = 1'b0;
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_divzero", {63'd0, DivZero}, 64'd0);
        check("rst_quotient", {32'd0, Quotient}, 64'd0);
        check("rst_remainder", {32'd0, Remainder}, 64'd0);
        chk_en = 1'b1;
        Reset = 1'b0;
        @(negedge Clk);

        run_op(32'd100, 32'd7, lat, bcnt);
        check("100/7_latency", 64'(lat), 64'd33);
        check("100/7_busy_cycles", 64'(bcnt), 64'd32);
        check("100/7_q", {32'd0, Quotient}, 64'd14);
        check("100/7_r", {32'd0, Remainder}, 64'd2);
        check("100/7_dz", {63'd0, DivZero}, 64'd0);
        @(negedge Clk);
        check("100/7_done_pulse", {63'd0, Done}, 64'd0);
        check("100/7_q_held", {32'd0, Quotient}, 64'd14);

        run_op(32'hFFFFFFFF, 32'd1, lat, bcnt);
        check("max/1_q", {32'd0, Quotient}, 64'hFFFFFFFF);
        check("max/1_r", {32'd0, Remainder}, 64'd0);
        @(negedge Clk);

        run_op(32'hFFFFFFFF, 32'h80000000, lat, bcnt);
        check("max/msb_q", {32'd0, Quotient}, 64'd1);
        check("max/msb_r", {32'd0, Remainder}, 64'h7FFFFFFF);
        @(negedge Clk);

        run_op(32'd5, 32'd0, lat, bcnt);
        check("5/0_latency", 64'(lat), 64'd1);
        check("5/0_busy_cycles", 64'(bcnt), 64'd0);
        check("5/0_busy_now", {63'd0, Busy}, 64'd0);
        check("5/0_q", {32'd0, Quotient}, 64'hFFFFFFFF);
        check("5/0_r", {32'd0, Remainder}, 64'd5);
        check("5/0_dz", {63'd0, DivZero}, 64'd1);
        @(negedge Clk);
        check("5/0_dz_held", {63'd0, DivZero}, 64'd1);

        for (int i = 0; i < 4; i++) begin
            run_op(tbl_dd[i], tbl_dv[i], lat, bcnt);
            check("identity", 64'(Quotient) * 64'(tbl_dv[i]) + 64'(Remainder), 64'(tbl_dd[i]));
            check("rem_lt_div", {63'd0, Remainder < tbl_dv[i]}, 64'd1);
            @(negedge Clk);
        end

        // Second Start mid-CALC with new operands must be ignored
        Dividend = 32'd3; Divisor = 32'd10; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        Dividend = 32'd50; Divisor = 32'd5; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        lat = 0;
        while (!Done && lat < 100) begin @(negedge Clk); lat++; end
        if (!Done) check("ignore_timeout", 64'd0, 64'd1);
        check("3/10_q", {32'd0, Quotient}, 64'd0);
        check("3/10_r", {32'd0, Remainder}, 64'd3);
        @(negedge Clk);
        check("3/10_no_requeue", {63'd0, Busy}, 64'd0);
        @(negedge Clk);

        // Reset in cycle 16 of CALC aborts with no Done
        Dividend = 32'd1000; Divisor = 32'd3; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (15) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check("abort_done", {63'd0, Done}, 64'd0);
        check("abort_divzero", {63'd0, DivZero}, 64'd0);
        check("abort_quotient", {32'd0, Quotient}, 64'd0);
        check("abort_remainder", {32'd0, Remainder}, 64'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);

        run_op(32'd81, 32'd9, lat, bcnt);
        check("81/9_latency", 64'(lat), 64'd33);
        check("81/9_q", {32'd0, Quotient}, 64'd9);
        check("81/9_r", {32'd0, Remainder}, 64'd0);
        repeat (2) @(negedge Clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
